hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS datapath. Sits beside the ID stage and drives the PC write enable, IF/ID write and flush, and the ID/EX control-zeroing mux.
- Generalises the interlock-only hazard detector with the following:
  - Register-width parameter.
  - Forwarding-aware mode.
  - Multi-cycle load-use stalls for slow data memory.
  - Multi-cycle flush for late branch resolution.
  - $zero exclusion.
  - Saturating stall/flush performance counters.

Parameters:
- REG_W, 5, register-address width.
- FWD_EN, 1: 1 = forwarding present, only load-use and jr hazards stall; 0 = full interlock on ID_EX/EX_MEM/MEM_WB RegWrite matches.
- LOAD_STALL, 1, bubble cycles per load-use hazard (1..15).
- FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch/jump (1..3).
- CNT_W, 16, performance counter width.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high.
- IF_ID_Rs, IF_ID_Rt  in  REG_W  source registers of the instruction in ID.
- ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd  in  REG_W  destinations in later stages.
- ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite  in  1  write enables.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- jump, jumpReg, branchTaken  in  1  control-transfer resolved in ID.
- CntClear  in  1  synchronous clear of both counters.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register enable.
- control  out  1  1 = pass decoded controls, 0 = insert bubble.
- IF_ID_flush  out  1  zero the IF/ID register.
- StallCount, FlushCount  out  CNT_W  saturating cycle counters.

Behaviour:
- A stage matches when its RegWrite=1, its Rd!=0, and its Rd equals IF_ID_Rs or IF_ID_Rt.
- Load-use hazard (LU): ID_EX_MemRead=1 and an ID_EX match.
- Data hazard (DH):
  - FWD_EN=1: LU, or jumpReg=1 with IF_ID_Rs matching ID_EX or EX_MEM (Rs only).
  - FWD_EN=0: any stage match. For jumpReg, only Rs counts.
- Control transfer (CT): jump | jumpReg | branchTaken.
- FSM states: RUN, STALL, FLUSH. A 4-bit down-counter `cnt` is shared between STALL and FLUSH.
- Outputs are combinational from state and inputs:
  - Stall pattern: PCWrite=0, IF_ID_Write=0, control=0, IF_ID_flush=0.
  - Flush pattern: PCWrite=1, IF_ID_Write=0, control=1, IF_ID_flush=1.
  - Normal pattern: 1, 1, 1, 0.
- RUN priority: DH > CT > normal.
  - DH: stall pattern. If LU and LOAD_STALL>1, next state is STALL with cnt=LOAD_STALL-2. A non-LU DH stays in RUN and re-evaluates every cycle.
  - CT without DH: flush pattern. If FLUSH_CYCLES>1, next state is FLUSH with cnt=FLUSH_CYCLES-2.
  - A CT that coincides with a DH is not acted on; it is re-evaluated once the stall clears.
- STALL: stall pattern unconditionally; all inputs are ignored.
  - cnt==0 → RUN, otherwise cnt decrements.
- FLUSH: flush pattern unconditionally; CT inputs are ignored because the flushed slot is invalid.
  - cnt==0 → RUN, otherwise cnt decrements.
- Total cycles:
  - One load-use hazard gives exactly LOAD_STALL stall cycles.
  - One taken transfer gives exactly FLUSH_CYCLES flush cycles.
- Counters:
  - StallCount increments on every cycle with the stall pattern.
  - FlushCount increments on every cycle with the flush pattern.
  - Both saturate at all-ones and do not wrap.
  - CntClear has priority over increment; cleared value 0 visible next cycle.
- Reset (asynchronous, any state, including mid-STALL/FLUSH):
  - State=RUN, cnt=0, both counters=0.
  - While Reset=1 the outputs are forced to PCWrite=0, IF_ID_Write=0, control=0, IF_ID_flush=0.
- After Reset deasserts, outputs follow the RUN evaluation in the same cycle.
- All comparisons are REG_W bits wide. cnt is 4 bits; parameters outside the stated ranges are unsupported.

Test Plan:
- Reset mid-STALL (LOAD_STALL=3, assert Reset in the 2nd stall cycle) → outputs 0,0,0,0 immediately; after release with no hazard, outputs are 1,1,1,0 and StallCount=0.
- LOAD_STALL=3, FWD_EN=1, ID_EX_MemRead=1, ID_EX_RegWrite=1, ID_EX_Rd=8, IF_ID_Rt=8 for one cycle → exactly 3 consecutive cycles with PCWrite=0/control=0, then normal; StallCount=3.
- ID_EX_Rd=0, ID_EX_MemRead=1, ID_EX_RegWrite=1, IF_ID_Rs=0 → no stall (outputs 1,1,1,0).
- FWD_EN=0, EX_MEM_RegWrite=1, EX_MEM_Rd=5, IF_ID_Rs=5 held 2 cycles → 2 stall cycles. Same stimulus with FWD_EN=1 → no stall.
- FLUSH_CYCLES=2, branchTaken=1 for one cycle → 2 cycles of IF_ID_flush=1, PCWrite=1; FlushCount=2. A second branchTaken during the FLUSH cycle is ignored.
- jumpReg=1 with IF_ID_Rs=9, ID_EX_Rd=9, ID_EX_RegWrite=1 (FWD_EN=1) → stall while the match persists, then one flush cycle. Separately, preload StallCount to all-ones via a long stall → the count holds at all-ones; CntClear → 0 on the next cycle.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage MIPS datapath: interlock/load-use stalls,
// multi-cycle IF/ID flushes for taken transfers, and saturating stall/flush counters.
module hazard_control_unit #(
  parameter int REG_W        = 5,
  parameter int FWD_EN       = 1,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic [REG_W-1:0] EX_MEM_Rd,
  input  logic [REG_W-1:0] MEM_WB_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             EX_MEM_RegWrite,
  input  logic             MEM_WB_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             jump,
  input  logic             jumpReg,
  input  logic             branchTaken,
  input  logic             CntClear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             control,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [3:0] LS_INIT = 4'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);
  localparam logic [3:0] FC_INIT = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [1:0]       w_state_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_stall;
  logic             w_flush;

  function automatic logic f_match(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] r);
    return we && (rd != '0) && (rd == r);
  endfunction

  logic w_ie_rs, w_ie_rt, w_em_rs, w_em_rt, w_mw_rs, w_mw_rt;
  logic w_lu, w_dh, w_ct;

  assign w_ie_rs = f_match(ID_EX_RegWrite,  ID_EX_Rd,  IF_ID_Rs);
  assign w_ie_rt = f_match(ID_EX_RegWrite,  ID_EX_Rd,  IF_ID_Rt);
  assign w_em_rs = f_match(EX_MEM_RegWrite, EX_MEM_Rd, IF_ID_Rs);
  assign w_em_rt = f_match(EX_MEM_RegWrite, EX_MEM_Rd, IF_ID_Rt);
  assign w_mw_rs = f_match(MEM_WB_RegWrite, MEM_WB_Rd, IF_ID_Rs);
  assign w_mw_rt = f_match(MEM_WB_RegWrite, MEM_WB_Rd, IF_ID_Rt);

  assign w_lu = ID_EX_MemRead && (w_ie_rs || w_ie_rt);
  assign w_ct = jump || jumpReg || branchTaken;

  // With forwarding only loads and jr (which reads Rs in ID) need to wait;
  // without it every pending write to a source register interlocks.
  assign w_dh = (FWD_EN != 0)
              ? (w_lu || (jumpReg && (w_ie_rs || w_em_rs)))
              : (w_lu || (jumpReg ? (w_ie_rs || w_em_rs || w_mw_rs)
                                  : (w_ie_rs || w_ie_rt || w_em_rs || w_em_rt ||
                                     w_mw_rs || w_mw_rt)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_dh) begin
          w_stall = 1'b1;
          if (w_lu && (LOAD_STALL > 1)) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = LS_INIT;
          end
        end else if (w_ct) begin
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = FC_INIT;
          end
        end
      end
      S_STALL: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (CntClear)                         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (CntClear)                         r_flush_cnt <= '0;
      else if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Reset forces every enable low regardless of state or inputs.
  assign PCWrite     = !Reset && !w_stall;
  assign IF_ID_Write = !Reset && !w_stall && !w_flush;
  assign control     = !Reset && !w_stall;
  assign IF_ID_flush = !Reset && w_flush;
  assign StallCount  = r_stall_cnt;
  assign FlushCount  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: two configurations driven in parallel,
// a vector table of single-cycle decisions, then multi-cycle stall/flush/reset/counter sequences.
module tb_hazard_control_unit;

  logic       Clk, Reset, CntClear;
  logic [4:0] rs, rt, ie_rd, em_rd, mw_rd;
  logic       ie_rw, em_rw, mw_rw, memrd, jmp, jr, br;

  logic       a_pc, a_ifw, a_ctl, a_fl, b_pc, b_ifw, b_ctl, b_fl;
  logic [3:0]  a_sc, a_fc;
  logic [15:0] b_sc, b_fc;
  logic [3:0]  a_out, b_out;
  assign a_out = {a_pc, a_ifw, a_ctl, a_fl};
  assign b_out = {b_pc, b_ifw, b_ctl, b_fl};

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] NRM = 4'b1110;
  localparam logic [3:0] STL = 4'b0000;
  localparam logic [3:0] FLS = 4'b1011;

  // A: forwarding, 3-cycle load-use, 2-cycle flush, tiny counters for saturation.
  hazard_control_unit #(.REG_W(5), .FWD_EN(1), .LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_EX_Rd(ie_rd),
    .EX_MEM_Rd(em_rd), .MEM_WB_Rd(mw_rd), .ID_EX_RegWrite(ie_rw), .EX_MEM_RegWrite(em_rw),
    .MEM_WB_RegWrite(mw_rw), .ID_EX_MemRead(memrd), .jump(jmp), .jumpReg(jr),
    .branchTaken(br), .CntClear(CntClear), .PCWrite(a_pc), .IF_ID_Write(a_ifw),
    .control(a_ctl), .IF_ID_flush(a_fl), .StallCount(a_sc), .FlushCount(a_fc));

  // B: full interlock, single-cycle stall and flush.
  hazard_control_unit #(.REG_W(5), .FWD_EN(0), .LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
    .Clk(Clk), .Reset(Reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_EX_Rd(ie_rd),
    .EX_MEM_Rd(em_rd), .MEM_WB_Rd(mw_rd), .ID_EX_RegWrite(ie_rw), .EX_MEM_RegWrite(em_rw),
    .MEM_WB_RegWrite(mw_rw), .ID_EX_MemRead(memrd), .jump(jmp), .jumpReg(jr),
    .branchTaken(br), .CntClear(CntClear), .PCWrite(b_pc), .IF_ID_Write(b_ifw),
    .control(b_ctl), .IF_ID_flush(b_fl), .StallCount(b_sc), .FlushCount(b_fc));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ie_rd, em_rd, mw_rd;
    logic       ie_rw, em_rw, mw_rw, memrd, jmp, jr, br;
    logic [3:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string nm, input logic [4:0] s, t, d1, d2, d3,
                              input logic w1, w2, w3, mr, j, r, b,
                              input logic [3:0] ea, eb);
    vec_t v;
    v.name = nm; v.rs = s; v.rt = t; v.ie_rd = d1; v.em_rd = d2; v.mw_rd = d3;
    v.ie_rw = w1; v.em_rw = w2; v.mw_rw = w3; v.memrd = mr;
    v.jmp = j; v.jr = r; v.br = b; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rs = 0; rt = 0; ie_rd = 0; em_rd = 0; mw_rd = 0;
    ie_rw = 0; em_rw = 0; mw_rw = 0; memrd = 0; jmp = 0; jr = 0; br = 0;
  endtask

  task automatic apply(input vec_t v);
    rs = v.rs; rt = v.rt; ie_rd = v.ie_rd; em_rd = v.em_rd; mw_rd = v.mw_rd;
    ie_rw = v.ie_rw; em_rw = v.em_rw; mw_rw = v.mw_rw; memrd = v.memrd;
    jmp = v.jmp; jr = v.jr; br = v.br;
  endtask

  task automatic load_use();
    idle(); memrd = 1; ie_rw = 1; ie_rd = 5'd8; rt = 5'd8;
  endtask

  task automatic clear_counters();
    @(negedge Clk); CntClear = 1;
    @(negedge Clk); CntClear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //           name         rs rt ieRd emRd mwRd ieW emW mwW mr  j  jr br  expA expB
    vecs[0]  = mk("idle",      0, 0, 0,  0,  0,   0,  0,  0,  0, 0, 0, 0, NRM, NRM);
    vecs[1]  = mk("lu_rt",     0, 8, 8,  0,  0,   1,  0,  0,  1, 0, 0, 0, STL, STL);
    vecs[2]  = mk("lu_zero",   0, 0, 0,  0,  0,   1,  0,  0,  1, 0, 0, 0, NRM, NRM);
    vecs[3]  = mk("exmem_rs",  5, 0, 0,  5,  0,   0,  1,  0,  0, 0, 0, 0, NRM, STL);
    vecs[4]  = mk("memwb_rt",  0, 7, 0,  0,  7,   0,  0,  1,  0, 0, 0, 0, NRM, STL);
    vecs[5]  = mk("memwb_nowe",0, 7, 0,  0,  7,   0,  0,  0,  0, 0, 0, 0, NRM, NRM);
    vecs[6]  = mk("branch",    0, 0, 0,  0,  0,   0,  0,  0,  0, 0, 0, 1, FLS, FLS);
    vecs[7]  = mk("jump",      0, 0, 0,  0,  0,   0,  0,  0,  0, 1, 0, 0, FLS, FLS);
    vecs[8]  = mk("jr_idex",   9, 0, 9,  0,  0,   1,  0,  0,  0, 0, 1, 0, STL, STL);
    vecs[9]  = mk("jr_rt_only",3, 9, 9,  0,  0,   1,  0,  0,  0, 0, 1, 0, FLS, FLS);
    vecs[10] = mk("jr_memwb",  4, 0, 0,  0,  4,   0,  0,  1,  0, 0, 1, 0, FLS, STL);
    vecs[11] = mk("br_exmem",  5, 0, 0,  5,  0,   0,  1,  0,  0, 0, 0, 1, FLS, STL);
    vecs[12] = mk("idex_alu",  6, 0, 6,  0,  0,   1,  0,  0,  0, 0, 0, 0, NRM, STL);

    Reset = 1; CntClear = 0; idle();
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_out_a", 32'(a_out), 32'(STL));
    chk("reset_out_b", 32'(b_out), 32'(STL));
    chk("reset_sc_a", 32'(a_sc), 0);
    chk("reset_fc_b", 32'(b_fc), 0);
    @(negedge Clk); Reset = 0; #1;
    chk("post_reset_a", 32'(a_out), 32'(NRM));

    for (int i = 0; i < 13; i++) begin
      @(negedge Clk); apply(vecs[i]); #1;
      chk({"vec_a_", vecs[i].name}, 32'(a_out), 32'(vecs[i].exp_a));
      chk({"vec_b_", vecs[i].name}, 32'(b_out), 32'(vecs[i].exp_b));
      @(negedge Clk); idle();
      repeat (3) @(negedge Clk);
    end

    // Load-use with LOAD_STALL=3: exactly three stall cycles.
    clear_counters();
    load_use(); #1; chk("lu_c0", 32'(a_out), 32'(STL));
    @(negedge Clk); idle(); #1; chk("lu_c1", 32'(a_out), 32'(STL));
    @(negedge Clk); #1; chk("lu_c2", 32'(a_out), 32'(STL));
    @(negedge Clk); #1; chk("lu_c3", 32'(a_out), 32'(NRM));
    chk("lu_sc", 32'(a_sc), 3);
    chk("lu_fc", 32'(a_fc), 0);

    // Two-cycle flush; a branch during FLUSH is ignored.
    clear_counters();
    br = 1; #1; chk("fl_c0", 32'(a_out), 32'(FLS));
    @(negedge Clk); #1; chk("fl_c1", 32'(a_out), 32'(FLS));
    @(negedge Clk); idle(); #1; chk("fl_c2", 32'(a_out), 32'(NRM));
    chk("fl_fc", 32'(a_fc), 2);

    // EX/MEM dependence held two cycles: interlock stalls, forwarding does not.
    clear_counters();
    em_rw = 1; em_rd = 5'd5; rs = 5'd5; #1;
    chk("em_b0", 32'(b_out), 32'(STL));
    chk("em_a0", 32'(a_out), 32'(NRM));
    @(negedge Clk); #1; chk("em_b1", 32'(b_out), 32'(STL));
    @(negedge Clk); idle(); #1;
    chk("em_b2", 32'(b_out), 32'(NRM));
    chk("em_sc_b", 32'(b_sc), 2);
    chk("em_sc_a", 32'(a_sc), 0);

    // jr waits for its Rs producer, then flushes.
    @(negedge Clk); jr = 1; rs = 5'd9; ie_rd = 5'd9; ie_rw = 1; #1;
    chk("jr_a0", 32'(a_out), 32'(STL)); chk("jr_b0", 32'(b_out), 32'(STL));
    @(negedge Clk); #1;
    chk("jr_a1", 32'(a_out), 32'(STL)); chk("jr_b1", 32'(b_out), 32'(STL));
    @(negedge Clk); ie_rw = 0; #1;
    chk("jr_a2", 32'(a_out), 32'(FLS)); chk("jr_b2", 32'(b_out), 32'(FLS));
    @(negedge Clk); idle(); #1;
    chk("jr_a3", 32'(a_out), 32'(FLS)); chk("jr_b3", 32'(b_out), 32'(NRM));
    @(negedge Clk); #1; chk("jr_a4", 32'(a_out), 32'(NRM));

    // Asynchronous reset in the second stall cycle.
    clear_counters();
    load_use();
    @(negedge Clk); idle(); Reset = 1; #1;
    chk("rst_mid_out", 32'(a_out), 32'(STL));
    chk("rst_mid_sc", 32'(a_sc), 0);
    @(negedge Clk); Reset = 0; #1;
    chk("rst_rel_out", 32'(a_out), 32'(NRM));
    chk("rst_rel_sc", 32'(a_sc), 0);
    @(negedge Clk); #1; chk("rst_rel_out2", 32'(a_out), 32'(NRM));

    // Long stall saturates the 4-bit counter; clear beats increment.
    load_use();
    repeat (20) @(negedge Clk);
    #1; chk("sat_sc", 32'(a_sc), 15);
    CntClear = 1;
    @(negedge Clk); CntClear = 0; #1; chk("sat_clr", 32'(a_sc), 0);
    @(negedge Clk); #1; chk("sat_after_clr", 32'(a_sc), 1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
